// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor
//   Watches the spike line from a LIF neuron, turns each rising edge into a single event, and
//   reports two figures:
//   - the number of events in each fixed window of WINDOW_CYCLES cycles;
//   - the number of cycles between consecutive events (inter-spike interval, ISI).
//
//   Build option SPIKE_BURST_DETECT_EN: when defined, burst_out pulses together with isi_valid
//   whenever the reported ISI is <= BURST_ISI. When it is undefined, burst_out is tied to 0.
//
// Ports
//   clk        system clock; all logic changes on its rising edge
//   rst        synchronous, active-high reset
//   spike      spike level from the neuron; it may stay high for several cycles
//   clear      synchronous soft clear of the measurement state
//   rate_out   event count of the last completed window (saturating)
//   rate_valid one-cycle pulse when rate_out updates
//   isi_out    most recent inter-spike interval in cycles (saturating)
//   isi_valid  one-cycle pulse when isi_out updates
//   burst_out  burst flag, aligned with isi_valid
module spike_rate_monitor #(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned ISI_W         = 16,
  parameter int unsigned BURST_ISI     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike,
  input  logic             clear,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             burst_out
);

  localparam int unsigned WinW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WinW-1:0]  WinLast = WinW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [ISI_W-1:0] IsiMax  = '1;

  typedef enum logic [0:0] {StIdle, StTrack} isi_state_e;

  isi_state_e       state_q, state_d;
  logic             spike_d_q;
  logic [WinW-1:0]  win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ISI_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             rate_valid_q, rate_valid_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             isi_valid_q, isi_valid_d;
  logic             spike_event, terminal;

  always_comb begin
    spike_event = spike & ~spike_d_q;
    terminal    = (win_q == WinLast);
    // An event on the terminal cycle still belongs to the window that is closing.
    cnt_inc     = (spike_event && (cnt_q != CntMax)) ? cnt_q + 1'b1 : cnt_q;

    win_d        = terminal ? '0 : win_q + 1'b1;
    cnt_d        = cnt_inc;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    if (terminal) begin
      rate_d       = cnt_inc;
      rate_valid_d = 1'b1;
      cnt_d        = '0;
    end

    state_d     = state_q;
    timer_d     = timer_q;
    isi_d       = isi_q;
    isi_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (spike_event) begin
          state_d = StTrack;
          timer_d = ISI_W'(1);
        end
      end
      StTrack: begin
        if (spike_event) begin
          isi_d       = timer_q;
          isi_valid_d = 1'b1;
          timer_d     = ISI_W'(1);
        end else if (timer_q != IsiMax) begin
          timer_d = timer_q + 1'b1;
        end
      end
    endcase

    // A clear drops everything in flight but keeps the last reported results.
    if (clear) begin
      win_d        = '0;
      cnt_d        = '0;
      timer_d      = '0;
      state_d      = StIdle;
      rate_d       = rate_q;
      rate_valid_d = 1'b0;
      isi_d        = isi_q;
      isi_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      spike_d_q    <= 1'b0;
      win_q        <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      spike_d_q    <= spike;  // keeps updating during clear so a held level is not re-counted
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  assign rate_out   = rate_q;
  assign rate_valid = rate_valid_q;
  assign isi_out    = isi_q;
  assign isi_valid  = isi_valid_q;

`ifdef SPIKE_BURST_DETECT_EN
  localparam logic [ISI_W-1:0] BurstIsi = ISI_W'(BURST_ISI);

  logic burst_q, burst_d;

  // isi_valid_d already goes low on clear, so burst_d is cleared by clear as well.
  always_comb begin
    burst_d = isi_valid_d & (timer_q <= BurstIsi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= 1'b0;
    end else begin
      burst_q <= burst_d;
    end
  end

  assign burst_out = burst_q;
`else
  assign burst_out = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed self-checking bench for spike_rate_monitor.
// Edge indices count from the first rising edge after rst is released (edge 0).
module tb_spike_rate_monitor;

  logic clk = 1'b0;
  logic rst, clear, spike, spike_s;
  logic [7:0]  rate_out;
  logic        rate_valid, isi_valid, burst_out;
  logic [15:0] isi_out;
  logic [3:0]  rate_out_s, isi_out_s;
  logic        rate_valid_s, isi_valid_s, burst_out_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spike_rate_monitor #(
    .WINDOW_CYCLES(16), .CNT_W(8), .ISI_W(16), .BURST_ISI(4)
  ) dut (
    .clk(clk), .rst(rst), .spike(spike), .clear(clear),
    .rate_out(rate_out), .rate_valid(rate_valid),
    .isi_out(isi_out), .isi_valid(isi_valid), .burst_out(burst_out)
  );

  spike_rate_monitor #(
    .WINDOW_CYCLES(64), .CNT_W(4), .ISI_W(4), .BURST_ISI(4)
  ) dut_sat (
    .clk(clk), .rst(rst), .spike(spike_s), .clear(clear),
    .rate_out(rate_out_s), .rate_valid(rate_valid_s),
    .isi_out(isi_out_s), .isi_valid(isi_valid_s), .burst_out(burst_out_s)
  );

  task automatic tick(input logic s, input logic ss);
    spike   = s;
    spike_s = ss;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    clear = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(i == 0, i == 0);
      total++;
      if ({rate_out, rate_valid, isi_out, isi_valid, burst_out} !== 27'd0) begin
        bad++;
        $display("FAIL reset_main[%0d]: got rate=%0d rv=%0b isi=%0d iv=%0b b=%0b want all 0",
                 i, rate_out, rate_valid, isi_out, isi_valid, burst_out);
      end
      total++;
      if ({rate_out_s, rate_valid_s, isi_out_s, isi_valid_s, burst_out_s} !== 11'd0) begin
        bad++;
        $display("FAIL reset_sat[%0d]: got rate=%0d rv=%0b isi=%0d iv=%0b b=%0b want all 0",
                 i, rate_out_s, rate_valid_s, isi_out_s, isi_valid_s, burst_out_s);
      end
    end
    rst = 1'b0;
    tick(1'b1, 1'b1);
    total++;
    if ({isi_valid, isi_valid_s} !== 2'b00) begin
      bad++;
      $display("FAIL reset_first_event: got isi_valid=%0b/%0b want 0/0", isi_valid, isi_valid_s);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_rate_isi();
    logic exp_iv, exp_rv;
    do_reset();
    for (int e = 0; e <= 16; e++) begin
      tick(e == 2 || e == 7 || e == 12, 1'b0);
      exp_iv = (e == 7 || e == 12);
      exp_rv = (e == 15);
      total++;
      if (isi_valid !== exp_iv) begin
        bad++;
        $display("FAIL rate_isi_iv@%0d: got %0b want %0b", e, isi_valid, exp_iv);
      end
      total++;
      if (rate_valid !== exp_rv) begin
        bad++;
        $display("FAIL rate_isi_rv@%0d: got %0b want %0b", e, rate_valid, exp_rv);
      end
      if (exp_iv) begin
        total++;
        if (isi_out !== 16'd5) begin
          bad++;
          $display("FAIL rate_isi_isi@%0d: got %0d want 5", e, isi_out);
        end
      end
      if (exp_rv) begin
        total++;
        if (rate_out !== 8'd3) begin
          bad++;
          $display("FAIL rate_isi_rate@%0d: got %0d want 3", e, rate_out);
        end
      end
    end
  endtask

  task automatic test_held_level();
    logic exp_rv;
    logic [7:0] exp_rate;
    logic [15:0] exp_isi;
    do_reset();
    for (int e = 0; e <= 31; e++) begin
      tick((e >= 3 && e <= 12) || e == 15, 1'b0);
      exp_rv   = (e == 15 || e == 31);
      exp_rate = (e >= 15 && e < 31) ? 8'd2 : 8'd0;
      exp_isi  = (e >= 15) ? 16'd12 : 16'd0;
      total++;
      if (rate_valid !== exp_rv) begin
        bad++;
        $display("FAIL held_rv@%0d: got %0b want %0b", e, rate_valid, exp_rv);
      end
      total++;
      if (rate_out !== exp_rate) begin
        bad++;
        $display("FAIL held_rate@%0d: got %0d want %0d", e, rate_out, exp_rate);
      end
      total++;
      if (isi_out !== exp_isi) begin
        bad++;
        $display("FAIL held_isi@%0d: got %0d want %0d", e, isi_out, exp_isi);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int e = 0; e <= 63; e++) begin
      tick(1'b0, (e % 3) == 1);
      total++;
      if (rate_valid_s !== (e == 63)) begin
        bad++;
        $display("FAIL sat_rv@%0d: got %0b want %0b", e, rate_valid_s, e == 63);
      end
    end
    total++;
    if (rate_out_s !== 4'd15) begin
      bad++;
      $display("FAIL sat_rate: got %0d want 15", rate_out_s);
    end
    total++;
    if (isi_out_s !== 4'd3) begin
      bad++;
      $display("FAIL sat_isi3: got %0d want 3", isi_out_s);
    end
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      tick(e == 0 || e == 40, e == 0 || e == 40);
      total++;
      if (isi_valid_s !== (e == 40)) begin
        bad++;
        $display("FAIL sat_iv@%0d: got %0b want %0b", e, isi_valid_s, e == 40);
      end
    end
    total++;
    if (isi_out_s !== 4'd15) begin
      bad++;
      $display("FAIL sat_isi: got %0d want 15", isi_out_s);
    end
    total++;
    if (isi_out !== 16'd40) begin
      bad++;
      $display("FAIL wide_isi: got %0d want 40", isi_out);
    end
  endtask

  task automatic test_clear();
    logic s, exp_iv, exp_rv;
    logic [7:0] exp_rate;
    logic [15:0] exp_isi;
    exp_rate = 8'd0;
    exp_isi  = 16'd0;
    do_reset();
    for (int e = 0; e <= 41; e++) begin
      s = (e == 2 || e == 7 || e == 12 || e == 18 || e == 20 || e == 22 ||
           (e >= 24 && e <= 26) || e == 28 || e == 35);
      clear = (e == 24);
      tick(s, 1'b0);
      exp_rv = (e == 15 || e == 40);
      exp_iv = (e == 7 || e == 12 || e == 18 || e == 20 || e == 22 || e == 35);
      if (e == 15) exp_rate = 8'd3;
      if (e == 40) exp_rate = 8'd2;
      if (e == 7) exp_isi = 16'd5;
      if (e == 18) exp_isi = 16'd6;
      if (e == 20) exp_isi = 16'd2;
      if (e == 35) exp_isi = 16'd7;
      total++;
      if (rate_valid !== exp_rv) begin
        bad++;
        $display("FAIL clear_rv@%0d: got %0b want %0b", e, rate_valid, exp_rv);
      end
      total++;
      if (isi_valid !== exp_iv) begin
        bad++;
        $display("FAIL clear_iv@%0d: got %0b want %0b", e, isi_valid, exp_iv);
      end
      total++;
      if (rate_out !== exp_rate) begin
        bad++;
        $display("FAIL clear_rate@%0d: got %0d want %0d", e, rate_out, exp_rate);
      end
      total++;
      if (isi_out !== exp_isi) begin
        bad++;
        $display("FAIL clear_isi@%0d: got %0d want %0d", e, isi_out, exp_isi);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_burst();
    logic exp_iv, exp_b;
    logic [15:0] exp_isi;
    do_reset();
    for (int e = 0; e <= 15; e++) begin
      tick(e == 0 || e == 3 || e == 7 || e == 13, 1'b0);
      exp_iv = (e == 3 || e == 7 || e == 13);
`ifdef SPIKE_BURST_DETECT_EN
      exp_b = (e == 3 || e == 7);
`else
      exp_b = 1'b0;
`endif
      exp_isi = (e == 3) ? 16'd3 : (e == 7) ? 16'd4 : 16'd6;
      total++;
      if (isi_valid !== exp_iv) begin
        bad++;
        $display("FAIL burst_iv@%0d: got %0b want %0b", e, isi_valid, exp_iv);
      end
      total++;
      if (burst_out !== exp_b) begin
        bad++;
        $display("FAIL burst_flag@%0d: got %0b want %0b", e, burst_out, exp_b);
      end
      if (exp_iv) begin
        total++;
        if (isi_out !== exp_isi) begin
          bad++;
          $display("FAIL burst_isi@%0d: got %0d want %0d", e, isi_out, exp_isi);
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    clear   = 1'b0;
    spike   = 1'b0;
    spike_s = 1'b0;
    test_reset();
    test_rate_isi();
    test_held_level();
    test_saturation();
    test_clear();
    test_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
